// File: rtl/instruction_sender.sv
// Byte-serial instruction sender for the GPU command bus: strobe/ack handshake per byte, then a commit gap.
// Optional per-byte ack timeout is compiled in with `define INSTRUCTION_SENDER_TIMEOUT_EN.
module instruction_sender #(
    parameter int COMMIT_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [2:0]  i_nbytes,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic        o_en,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    if (COMMIT_CYCLES < 1 || COMMIT_CYCLES > 15) begin : g_bad_commit_cycles
        $error("instruction_sender: COMMIT_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("instruction_sender: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RELEASE,
        COMMIT
    } state_t;

    localparam logic [3:0] COMMIT_LOAD = 4'(COMMIT_CYCLES - 1);

    state_t      state;
    logic [31:0] shift_reg;
    logic [2:0]  byte_cnt;
    logic [3:0]  commit_cnt;
    logic [2:0]  nbytes_clamped;

`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;
    logic               error_q;

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    // Out-of-range byte counts (0, 5..7) fall back to a full 4-byte word.
    always_comb begin
        nbytes_clamped = 3'd4;
        if (i_nbytes >= 3'd1 && i_nbytes <= 3'd4) begin
            nbytes_clamped = i_nbytes;
        end
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            byte_cnt   <= '0;
            commit_cnt <= '0;
            o_data     <= '0;
            o_we       <= 1'b1;
            o_en       <= 1'b1;
            o_done     <= 1'b0;
`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
            timer      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift_reg <= i_instr;
                        byte_cnt  <= nbytes_clamped;
                        o_data    <= i_instr[7:0];
                        o_we      <= 1'b0;
                        o_en      <= 1'b0;
                        state     <= STROBE;
`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
                        timer     <= TIMER_LOAD;
`endif
                    end
                end

                STROBE: begin
                    if (i_ack) begin
                        o_en  <= 1'b1;
                        state <= RELEASE;
                    end
`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
                    // Give up on the whole instruction; nothing is committed.
                    else if (timer == '0) begin
                        shift_reg <= '0;
                        byte_cnt  <= '0;
                        o_data    <= '0;
                        o_we      <= 1'b1;
                        o_en      <= 1'b1;
                        error_q   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end

                RELEASE: begin
                    if (!i_ack) begin
                        shift_reg <= {8'd0, shift_reg[31:8]};
                        byte_cnt  <= byte_cnt - 3'd1;
                        if (byte_cnt == 3'd1) begin
                            o_data     <= '0;
                            o_we       <= 1'b1;
                            commit_cnt <= COMMIT_LOAD;
                            state      <= COMMIT;
                        end else begin
                            o_data <= shift_reg[15:8];
                            o_en   <= 1'b0;
                            state  <= STROBE;
`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
                            timer  <= TIMER_LOAD;
`endif
                        end
                    end
                end

                COMMIT: begin
                    if (commit_cnt == 4'd0) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        commit_cnt <= commit_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sender.sv
// Directed bench for instruction_sender: table of instructions plus hand-written reset/ack/timeout sequences.
module tb_instruction_sender;

    localparam int COMMIT_CYCLES  = 2;
    localparam int TIMEOUT_CYCLES = 8;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [2:0]  i_nbytes;
    logic [7:0]  o_data;
    logic        o_we;
    logic        o_en;
    logic        i_ack;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  nbytes;
        int          delay_byte;
        int          delay;
        logic [31:0] exp_bytes;
        int          exp_n;
    } vec_t;

    vec_t vecs [7];

    instruction_sender #(
        .COMMIT_CYCLES (COMMIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_instr (i_instr),
        .i_nbytes(i_nbytes),
        .o_data  (o_data),
        .o_we    (o_we),
        .o_en    (o_en),
        .i_ack   (i_ack),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_error (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, o_ready, 1);
        checkOutput({tag, "_we"},    o_we,    1);
        checkOutput({tag, "_en"},    o_en,    1);
        checkOutput({tag, "_data"},  o_data,  0);
        checkOutput({tag, "_busy"},  o_busy,  0);
        checkOutput({tag, "_done"},  o_done,  0);
        checkOutput({tag, "_error"}, o_error, 0);
    endtask

    // Waits (bounded) through the commit gap and checks the single done pulse.
    task automatic waitDone(input string tag, inout int n, output int commit_len);
        commit_len = 0;
        while (o_done !== 1'b1 && commit_len < 40) begin
            checkOutput({tag, "_commit_we"},   o_we,   1);
            checkOutput({tag, "_commit_en"},   o_en,   1);
            checkOutput({tag, "_commit_data"}, o_data, 0);
            commit_len++;
            @(negedge i_clk);
            n++;
        end
        checkOutput({tag, "_done_seen"},  o_done,  1);
        checkOutput({tag, "_done_ready"}, o_ready, 1);
        checkOutput({tag, "_done_busy"},  o_busy,  0);
        checkOutput({tag, "_done_error"}, o_error, 0);
        @(negedge i_clk);
        checkOutput({tag, "_done_single"}, o_done, 0);
    endtask

    // Called on a negedge with the DUT idle; acts as the receiver for one instruction.
    task automatic applyStimulus(input vec_t v);
        int n;
        int commit_len;
        logic [7:0] exp_byte;
        checkOutput("accept_ready", o_ready, 1);
        i_valid  = 1'b1;
        i_instr  = v.instr;
        i_nbytes = v.nbytes;
        @(negedge i_clk);
        n        = 0;
        i_valid  = 1'b0;
        i_instr  = '0;
        i_nbytes = '0;
        for (int b = 0; b < v.exp_n; b++) begin
            exp_byte = v.exp_bytes[8*b +: 8];
            checkOutput("strobe_en",    o_en,    0);
            checkOutput("strobe_we",    o_we,    0);
            checkOutput("strobe_data",  o_data,  exp_byte);
            checkOutput("strobe_ready", o_ready, 0);
            checkOutput("strobe_busy",  o_busy,  1);
            if (b == v.delay_byte) begin
                for (int d = 0; d < v.delay; d++) begin
                    @(negedge i_clk);
                    n++;
                    checkOutput("hold_en",   o_en,   0);
                    checkOutput("hold_we",   o_we,   0);
                    checkOutput("hold_data", o_data, exp_byte);
                end
            end
            i_ack = 1'b1;
            @(negedge i_clk);
            n++;
            checkOutput("release_en",   o_en,   1);
            checkOutput("release_we",   o_we,   0);
            checkOutput("release_data", o_data, exp_byte);
            i_ack = 1'b0;
            @(negedge i_clk);
            n++;
        end
        waitDone("vec", n, commit_len);
        checkOutput("commit_len", commit_len, COMMIT_CYCLES);
        checkOutput("latency", n, 2 * v.exp_n + v.delay + COMMIT_CYCLES);
    endtask

    initial begin
        int n;
        int commit_len;
        vec_t v;

        vecs[0] = '{32'h44332211, 3'd4, 0, 0, 32'h44332211, 4};
        vecs[1] = '{32'h000000A5, 3'd1, 0, 0, 32'h000000A5, 1};
        vecs[2] = '{32'hDEADBEEF, 3'd4, 1, 5, 32'hDEADBEEF, 4};
        vecs[3] = '{32'h12345678, 3'd0, 0, 0, 32'h12345678, 4};
        vecs[4] = '{32'h12345678, 3'd7, 0, 0, 32'h12345678, 4};
        vecs[5] = '{32'hCAFEF00D, 3'd2, 0, 0, 32'h0000F00D, 2};
        vecs[6] = '{32'h00ABCDEF, 3'd3, 0, 2, 32'h00ABCDEF, 3};

        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_instr  = '0;
        i_nbytes = '0;
        i_ack    = 1'b0;
        repeat (2) @(negedge i_clk);
        checkIdleOutputs("reset");
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d instr=%h nbytes=%0d", i, vecs[i].instr, vecs[i].nbytes);
            applyStimulus(vecs[i]);
        end

        // Ack held high while idle is ignored, and already-high ack completes the first byte at once.
        i_ack = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("idle_ack_en",    o_en,    1);
        checkOutput("idle_ack_ready", o_ready, 1);
        checkOutput("idle_ack_busy",  o_busy,  0);
        i_valid  = 1'b1;
        i_instr  = 32'h0000003C;
        i_nbytes = 3'd1;
        @(negedge i_clk);
        i_valid = 1'b0;
        checkOutput("early_ack_strobe_en",   o_en,   0);
        checkOutput("early_ack_strobe_data", o_data, 8'h3C);
        @(negedge i_clk);
        checkOutput("early_ack_release_en", o_en, 1);
        checkOutput("early_ack_release_we", o_we, 0);
        i_ack = 1'b0;
        @(negedge i_clk);
        n = 0;
        waitDone("early_ack", n, commit_len);
        checkOutput("early_ack_commit_len", commit_len, COMMIT_CYCLES);

        // A second request held during the transfer must not replace or follow the first.
        i_valid  = 1'b1;
        i_instr  = 32'h0000005A;
        i_nbytes = 3'd1;
        @(negedge i_clk);
        i_instr  = 32'h77777777;
        i_nbytes = 3'd4;
        checkOutput("busy_valid_data", o_data, 8'h5A);
        i_ack = 1'b1;
        @(negedge i_clk);
        i_ack = 1'b0;
        @(negedge i_clk);
        checkOutput("busy_valid_commit_we", o_we, 1);
        i_valid = 1'b0;
        n = 0;
        waitDone("busy_valid", n, commit_len);
        repeat (3) @(negedge i_clk);
        checkOutput("busy_valid_no_strobe", o_en,   1);
        checkOutput("busy_valid_idle",      o_busy, 0);

        // Reset in RELEASE after byte 2 drops the instruction; a new one is accepted right after.
        i_valid  = 1'b1;
        i_instr  = 32'h44332211;
        i_nbytes = 3'd4;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ack   = 1'b1;
        @(negedge i_clk);
        i_ack = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_byte2_data", o_data, 8'h22);
        i_ack = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_release_en", o_en, 1);
        i_reset = 1'b1;
        i_ack   = 1'b0;
        @(negedge i_clk);
        checkIdleOutputs("midreset");
        i_reset = 1'b0;
        v = '{32'h000000C3, 3'd1, 0, 0, 32'h000000C3, 1};
        applyStimulus(v);

`ifdef INSTRUCTION_SENDER_TIMEOUT_EN
        i_valid  = 1'b1;
        i_instr  = 32'h00000099;
        i_nbytes = 3'd2;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        checkOutput("timeout_strobe_en", o_en, 0);
        while (o_error !== 1'b1 && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("timeout_error_seen", o_error, 1);
        checkOutput("timeout_delay",      n,       TIMEOUT_CYCLES);
        checkOutput("timeout_en",         o_en,    1);
        checkOutput("timeout_we",         o_we,    1);
        checkOutput("timeout_done",       o_done,  0);
        checkOutput("timeout_ready",      o_ready, 1);
        @(negedge i_clk);
        checkOutput("timeout_error_single", o_error, 0);
        checkOutput("timeout_no_done",      o_done,  0);
        checkOutput("timeout_dropped",      o_en,    1);
`else
        i_valid  = 1'b1;
        i_instr  = 32'h00000099;
        i_nbytes = 3'd2;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (100) @(negedge i_clk);
        checkOutput("no_timeout_en",    o_en,    0);
        checkOutput("no_timeout_busy",  o_busy,  1);
        checkOutput("no_timeout_data",  o_data,  8'h99);
        checkOutput("no_timeout_error", o_error, 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checkIdleOutputs("final_reset");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
